// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop synchronizer, oversampled 2-of-3 majority vote per bit,
// start/stop checking and a valid/ack byte handshake with sticky overrun.
module uart_rx_sampler #(
  parameter int SAMPLE_RATE = 10,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 RsRx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [SW-1:0] IDX_LO   = SW'(SAMPLE_RATE / 2 - 1);
  localparam logic [SW-1:0] IDX_MID  = SW'(SAMPLE_RATE / 2);
  localparam logic [SW-1:0] IDX_HI   = SW'(SAMPLE_RATE / 2 + 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          scnt_q, scnt_d, scnt_inc;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [1:0]             ones_q, ones_d;
  logic                   rx_meta, rx_s;
  logic                   vote, frame_good, frame_bad;

  // The line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RsRx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      ones_q  <= '0;
    end else if (sample_en) begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      ones_q  <= ones_d;
    end
  end

  // ones_q counts the high samples seen at IDX_LO and IDX_MID; the IDX_HI sample completes the vote.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    ones_d     = ones_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    vote       = (ones_q + {1'b0, rx_s}) >= 2'd2;
    scnt_inc   = (scnt_q == IDX_LAST) ? '0 : scnt_q + 1'b1;

    if (scnt_q == IDX_LO)       ones_d = {1'b0, rx_s};
    else if (scnt_q == IDX_MID) ones_d = ones_q + {1'b0, rx_s};

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          scnt_d  = SW'(1);
        end
      end
      START: begin
        scnt_d = scnt_inc;
        if (scnt_q == IDX_HI && vote) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else if (scnt_q == IDX_LAST) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        scnt_d = scnt_inc;
        if (scnt_q == IDX_HI) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        if (scnt_q == IDX_LAST) begin
          if (bcnt_q == LAST_BIT) state_d = STOP;
          else                    bcnt_d  = bcnt_q + 1'b1;
        end
      end
      STOP: begin
        scnt_d = scnt_inc;
        // Leave mid-stop-bit so a back-to-back start edge is always seen from IDLE.
        if (scnt_q == IDX_HI) begin
          scnt_d = '0;
          if (vote) begin
            state_d    = IDLE;
            frame_good = 1'b1;
          end else begin
            state_d   = WAIT_IDLE;
            frame_bad = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and frame_err run every clk; only frame completion is gated by sample_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= sample_en & frame_bad;
      if (sample_en && frame_good) begin
        rx_data  <= shreg_q;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
